// File: rtl/spad_stream_reader.sv
// spad_stream_reader
//   Read-side master for a dual-port scratchpad. Accepts a (base, length)
//   command. Walks the scratchpad's combinational read port one word per
//   cycle. Streams the words out over valid/ready, marking the final beat
//   with out_last.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   cmd_valid/ready  : command handshake
//   cmd_base         : first word address
//   cmd_len          : number of words (0 allowed, may exceed DEPTH)
//   spad_raddr       : scratchpad read address (always the address register)
//   spad_rdata       : scratchpad read data, combinational on spad_raddr
//   out_valid/ready  : output beat handshake
//   out_data         : streamed word
//   out_last         : final beat of the command
//   busy             : command in progress
//   done             : one-cycle completion pulse
module spad_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic [ADDR_WIDTH-1:0] spad_raddr,
  input  logic [DATA_WIDTH-1:0] spad_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic                  r_done;

  logic w_cmd_fire;
  logic w_slot_free;
  logic w_load;
  logic w_last_fire;

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  // The single output register can take a new word when it is empty or
  // its current word is being consumed at this edge.
  assign w_slot_free = !r_out_valid || out_ready;
  // r_rem is zero whenever the FSM is idle, so this only fires in RUN.
  assign w_load      = w_slot_free && (r_rem != '0);
  assign w_last_fire = r_out_valid && out_ready && r_out_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero-length command never leaves IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_fire && (cmd_len != '0)) w_state_next = S_RUN;
      S_RUN:  if (w_last_fire)                   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE:  cmd_ready = 1'b1;
      S_RUN:   busy      = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Address walker and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_cmd_fire && (cmd_len == '0)) || w_last_fire;

      if (w_cmd_fire) begin
        r_addr <= cmd_base;
        r_rem  <= cmd_len;
      end else if (w_load) begin
        // Natural wrap at DEPTH-1 -> 0 from the fixed register width.
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_rem  <= r_rem - (ADDR_WIDTH + 1)'(1);
      end

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= spad_rdata;
        r_out_last  <= (r_rem == (ADDR_WIDTH + 1)'(1));
      end else if (w_slot_free) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign spad_raddr = r_addr;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign done       = r_done;

endmodule

// File: tb/tb_spad_stream_reader.sv
// Testbench for spad_stream_reader: directed scenarios followed by randomized
// commands. Expected streams are computed from the scratchpad contents as
// (base + k) mod DEPTH for k < len.
module tb_spad_stream_reader;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] spad_raddr;
  logic [DW-1:0] spad_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int n_pass  = 0;
  int n_total = 0;

  assign spad_rdata = mem[spad_raddr];

  spad_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_len    (cmd_len),
    .spad_raddr (spad_raddr),
    .spad_rdata (spad_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Issues one command from a negedge and consumes its stream.
  // rmode: 0 = out_ready always 1, 1 = pattern 1,0,0,1,0,1, 2 = random.
  // hold_base >= 0: keep cmd_valid asserted with that base while busy and
  // return in the done cycle so the held command is accepted back-to-back.
  task automatic run_cmd(input int base, input int len, input int rmode,
                         input int hold_base, input string tag);
    logic [DW-1:0] exp_q[$];
    int            beats;
    int            cycles;
    int            budget;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_raddr;
    int            pat[6] = '{1, 0, 0, 1, 0, 1};

    for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % DEPTH]);

    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_len   = (AW + 1)'(len);
    out_ready = 1'b1;
    chk({tag, " cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    @(negedge clk);
    if (hold_base >= 0) begin
      cmd_base = AW'(hold_base);
      cmd_len  = (AW + 1)'(4);
    end else begin
      cmd_valid = 1'b0;
    end
    chk({tag, " raddr_after_accept"}, 64'(spad_raddr), 64'(base % DEPTH));

    if (len == 0) begin
      chk({tag, " len0_done"},  64'(done),      64'd1);
      chk({tag, " len0_busy"},  64'(busy),      64'd0);
      chk({tag, " len0_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, " len0_done_low"},  64'(done),      64'd0);
      chk({tag, " len0_valid_low"}, 64'(out_valid), 64'd0);
      return;
    end

    chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    beats      = 0;
    cycles     = 0;
    budget     = len * 8 + 20;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    prev_raddr = '0;
    while (beats < len && cycles < budget) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cycles % 6] != 0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (prev_stall) begin
        chk({tag, " stall_valid"}, 64'(out_valid),  64'd1);
        chk({tag, " stall_data"},  64'(out_data),   64'(prev_data));
        chk({tag, " stall_last"},  64'(out_last),   64'(prev_last));
        chk({tag, " stall_raddr"}, 64'(spad_raddr), 64'(prev_raddr));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s beat%0d_data", tag, beats), 64'(out_data), 64'(exp_q[beats]));
        chk($sformatf("%s beat%0d_last", tag, beats), 64'(out_last), 64'(beats == len - 1));
        chk($sformatf("%s beat%0d_busy", tag, beats), 64'({busy, done, cmd_ready}), 64'b100);
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_raddr = spad_raddr;
      @(negedge clk);
      cycles++;
    end
    chk({tag, " beats_received"}, 64'(beats), 64'(len));
    if (rmode == 0) chk({tag, " stream_cycles"}, 64'(cycles), 64'(len + 1));

    chk({tag, " done_pulse"},      64'(done),      64'd1);
    chk({tag, " busy_at_done"},    64'(busy),      64'd0);
    chk({tag, " ready_at_done"},   64'(cmd_ready), 64'd1);
    chk({tag, " valid_at_done"},   64'(out_valid), 64'd0);
    if (hold_base < 0) begin
      @(negedge clk);
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000 + i;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset cmd_ready", 64'(cmd_ready),  64'd1);
    chk("reset busy",      64'(busy),       64'd0);
    chk("reset done",      64'(done),       64'd0);
    chk("reset out_valid", 64'(out_valid),  64'd0);
    chk("reset out_last",  64'(out_last),   64'd0);
    chk("reset out_data",  64'(out_data),   64'd0);
    chk("reset raddr",     64'(spad_raddr), 64'd0);
    @(negedge clk);

    // Basic stream, wrap, backpressure, empty command
    run_cmd(4,    4, 0, -1, "basic");
    run_cmd(8'hFE, 4, 0, -1, "wrap");
    run_cmd(0,    8, 1, -1, "bp");
    run_cmd(17,   0, 0, -1, "len0");

    // Reset mid-command after two beats
    cmd_valid = 1'b1;
    cmd_base  = '0;
    cmd_len   = 9'd8;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst beat0", 64'(out_data), 64'h0000A000);
    @(negedge clk);
    chk("midrst beat1", 64'(out_data), 64'h0000A001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst valid",     64'(out_valid), 64'd0);
    chk("midrst busy",      64'(busy),      64'd0);
    chk("midrst cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst done",      64'(done),      64'd0);
    chk("midrst raddr",     64'(spad_raddr), 64'd0);
    @(negedge clk);
    chk("midrst no_done", 64'(done), 64'd0);
    run_cmd(0, 2, 0, -1, "after_rst");

    // cmd_valid held during a busy command, then accepted back-to-back
    run_cmd(4,    4, 0, 8'h20, "held_first");
    run_cmd(8'h20, 4, 0, -1,   "held_second");

    // Long command re-reading entries across multiple wraps
    run_cmd(250, 300, 0, -1, "long_wrap");

    // Randomized contents and commands
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int t = 0; t < 12; t++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 2)), -1, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
